// File: rtl/esp32_prog_bridge.sv
// ESP32 programming bridge: DTR/RTS strap decode with release window, SPI button report, multiboot request.
// Optional multiboot counter is built when ESP32_PROG_MULTIBOOT_EN is defined.
module esp32_prog_bridge #(
  parameter int unsigned C_sync_stages  = 2,
  parameter int unsigned C_release_bits = 17,
  parameter int unsigned C_btn_bits     = 7,
  parameter int unsigned C_shift_width  = 8,
  parameter int unsigned C_progn_bits   = 8
) (
  input  logic                  clk_25mhz,
  input  logic                  rstn,
  input  logic                  ftdi_ndtr,
  input  logic                  ftdi_nrts,
  input  logic [C_btn_bits-1:0] btn,
  input  logic                  spi_csn,
  input  logic                  spi_clk,
  output logic                  wifi_en,
  output logic                  wifi_gpio0,
  output logic                  strap_oe,
  output logic                  spi_miso,
  output logic                  user_programn,
  output logic                  prog_active
);

  localparam int unsigned LP_SYNC_W = 4;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [C_sync_stages-1:0][LP_SYNC_W-1:0] r_sync;
  logic [C_sync_stages-1:0]                r_vld;
  logic [LP_SYNC_W-1:0]                    w_async;
  logic [LP_SYNC_W-1:0]                    w_sync;
  logic [1:0]                              w_pair;
  logic [1:0]                              r_prev_pair;
  logic                                    w_sync_ok;
  logic                                    w_trigger;
  logic                                    w_csn;
  logic                                    w_sclk;
  logic                                    r_sclk_d;
  logic                                    r_en;
  logic                                    r_io0;
  logic                                    r_miso;
  logic [C_shift_width-1:0]                r_sh;
  state_t                                  r_state;
  state_t                                  w_state_next;
  logic [C_release_bits-1:0]               r_cnt;
  logic [C_release_bits-1:0]               w_cnt_next;

  assign w_async   = {spi_csn, spi_clk, ftdi_ndtr, ftdi_nrts};
  assign w_sync    = r_sync[C_sync_stages-1];
  assign w_pair    = w_sync[1:0];
  assign w_sclk    = w_sync[2];
  assign w_csn     = w_sync[3];
  assign w_sync_ok = r_vld[C_sync_stages-1];

  // r_vld marks when the chain holds real pin samples, so reset-time 1s never count as a seen 11
  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      r_sync      <= '1;
      r_vld       <= '0;
      r_prev_pair <= 2'b00;
      r_sclk_d    <= 1'b1;
    end else begin
      r_sync      <= {r_sync[C_sync_stages-2:0], w_async};
      r_vld       <= {r_vld[C_sync_stages-2:0], 1'b1};
      r_prev_pair <= w_sync_ok ? w_pair : 2'b00;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_trigger = w_sync_ok && (w_pair == 2'b10) && (r_prev_pair == 2'b11);

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      r_en  <= 1'b1;
      r_io0 <= 1'b1;
    end else begin
      r_en  <= (w_pair != 2'b10);
      r_io0 <= (w_pair != 2'b01) & btn[0];
    end
  end

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Retrigger takes priority over window expiry
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (w_trigger) begin
          w_cnt_next = '0;
        end else if (r_cnt == {C_release_bits{1'b1}}) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + C_release_bits'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Button report: parallel load while deselected, rotate on each synchronised SCK rise
  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      r_sh   <= '0;
      r_miso <= 1'b0;
    end else begin
      if (w_csn) begin
        r_sh <= C_shift_width'(btn);
      end else if (w_sclk && !r_sclk_d) begin
        r_sh <= {r_sh[C_shift_width-2:0], r_sh[C_shift_width-1]};
      end
      r_miso <= r_sh[C_shift_width-1];
    end
  end

`ifdef ESP32_PROG_MULTIBOOT_EN
  logic [C_progn_bits-1:0] r_pc;
  logic                    r_progn;
  logic                    w_mb_hold;

  assign w_mb_hold = ~btn[0] & btn[1];

  // Saturating hold counter; the request clears on the clock the buttons are released
  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      r_pc    <= '0;
      r_progn <= 1'b1;
    end else if (!w_mb_hold) begin
      r_pc    <= '0;
      r_progn <= 1'b1;
    end else begin
      if (!r_pc[C_progn_bits-1]) begin
        r_pc <= r_pc + C_progn_bits'(1);
      end
      r_progn <= ~r_pc[C_progn_bits-1];
    end
  end

  assign user_programn = r_progn;
`else
  assign user_programn = 1'b1;
`endif

  assign wifi_en     = r_en;
  assign wifi_gpio0  = r_io0;
  assign strap_oe    = (r_state == S_HOLD);
  assign prog_active = (r_state == S_HOLD);
  assign spi_miso    = r_miso;

endmodule

// File: tb/tb_esp32_prog_bridge.sv
// Directed bench for esp32_prog_bridge with a 16-clock release window.
module tb_esp32_prog_bridge;

  logic       clk_25mhz;
  logic       rstn;
  logic       ftdi_ndtr;
  logic       ftdi_nrts;
  logic [6:0] btn;
  logic       spi_csn;
  logic       spi_clk;
  logic       wifi_en;
  logic       wifi_gpio0;
  logic       strap_oe;
  logic       spi_miso;
  logic       user_programn;
  logic       prog_active;

  int n_vec;
  int n_err;

  esp32_prog_bridge #(
    .C_sync_stages (2),
    .C_release_bits(4),
    .C_btn_bits    (7),
    .C_shift_width (8),
    .C_progn_bits  (8)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .rstn         (rstn),
    .ftdi_ndtr    (ftdi_ndtr),
    .ftdi_nrts    (ftdi_nrts),
    .btn          (btn),
    .spi_csn      (spi_csn),
    .spi_clk      (spi_clk),
    .wifi_en      (wifi_en),
    .wifi_gpio0   (wifi_gpio0),
    .strap_oe     (strap_oe),
    .spi_miso     (spi_miso),
    .user_programn(user_programn),
    .prog_active  (prog_active)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic set_pair(input logic [1:0] p);
    ftdi_ndtr = p[1];
    ftdi_nrts = p[0];
  endtask

  task automatic watch_strap(input int n, output int first, output int last, output int cnt);
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_25mhz);
      if (strap_oe) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
  endtask

  int         f, l, c;
  logic [7:0] m_sh;
  logic       pn128, pn129, pn300;

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    set_pair(2'b11);
    btn = 7'h7F;
    spi_csn = 1'b1;
    spi_clk = 1'b0;

    // reset state
    step(3);
    check("rst_en", 32'(wifi_en), 32'd1);
    check("rst_gpio0", 32'(wifi_gpio0), 32'd1);
    check("rst_strap", 32'(strap_oe), 32'd0);
    check("rst_active", 32'(prog_active), 32'd0);
    check("rst_progn", 32'(user_programn), 32'd1);
    check("rst_miso", 32'(spi_miso), 32'd0);
    rstn = 1'b1;
    step(10);

    // 11 -> 10: EN low after 3 clocks, 16-clock strap window
    set_pair(2'b10);
    step(2);
    check("en_lat2", 32'(wifi_en), 32'd1);
    check("strap_lat2", 32'(strap_oe), 32'd0);
    step(1);
    check("en_lat3", 32'(wifi_en), 32'd0);
    check("strap_lat3", 32'(strap_oe), 32'd1);
    check("active_lat3", 32'(prog_active), 32'd1);
    watch_strap(17, f, l, c);
    check("win_total", 32'(c + 1), 32'd16);
    check("win_last", 32'(l), 32'd15);
    check("en_hold10", 32'(wifi_en), 32'd0);

    // 10 -> 01: IO0 low, EN high, no new window
    set_pair(2'b01);
    step(2);
    check("gpio0_lat2", 32'(wifi_gpio0), 32'd1);
    step(1);
    check("gpio0_01", 32'(wifi_gpio0), 32'd0);
    check("en_01", 32'(wifi_en), 32'd1);
    watch_strap(17, f, l, c);
    check("strap_01", 32'(c), 32'd0);
    set_pair(2'b11);
    step(20);
    check("gpio0_11", 32'(wifi_gpio0), 32'd1);
    check("en_11", 32'(wifi_en), 32'd1);

    // retrigger at cnt=10 extends the window with no gap (3..29 high)
    set_pair(2'b10);
    step(10);
    check("retrig_pre", 32'(strap_oe), 32'd1);
    set_pair(2'b11);
    step(1);
    set_pair(2'b10);
    watch_strap(30, f, l, c);
    check("retrig_first", 32'(f), 32'd1);
    check("retrig_last", 32'(l), 32'd18);
    check("retrig_cnt", 32'(c), 32'd18);
    set_pair(2'b11);
    step(10);

    // async reset mid-HOLD, then no window until 11 is seen again
    set_pair(2'b10);
    step(8);
    check("mid_hold", 32'(strap_oe), 32'd1);
    #5 rstn = 1'b0;
    #1;
    check("async_strap", 32'(strap_oe), 32'd0);
    check("async_active", 32'(prog_active), 32'd0);
    check("async_en", 32'(wifi_en), 32'd1);
    @(negedge clk_25mhz);
    rstn = 1'b1;
    watch_strap(30, f, l, c);
    check("no_rearm", 32'(c), 32'd0);
    set_pair(2'b11);
    step(6);
    set_pair(2'b10);
    step(3);
    check("rearm", 32'(strap_oe), 32'd1);
    set_pair(2'b11);
    step(25);
    check("rearm_done", 32'(strap_oe), 32'd0);

    // SPI report: btn=1010101 -> sh=0x55, SCK = clk/8
    btn = 7'b1010101;
    m_sh = 8'h55;
    step(5);
    spi_csn = 1'b0;
    step(5);
    check("miso_0", 32'(spi_miso), 32'(m_sh[7]));
    for (int p = 1; p <= 17; p++) begin
      spi_clk = 1'b1;
      m_sh = {m_sh[6:0], m_sh[7]};
      step(4);
      spi_clk = 1'b0;
      step(4);
      check($sformatf("miso_%0d", p), 32'(spi_miso), 32'(m_sh[7]));
    end
    spi_csn = 1'b1;
    step(5);
    check("miso_reload", 32'(spi_miso), 32'd0);

    // multiboot hold: btn0=0, btn1=1
    btn = 7'b1111110;
    pn128 = 1'b1;
    pn129 = 1'b1;
    pn300 = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk_25mhz);
      if (k == 128) pn128 = user_programn;
      if (k == 129) pn129 = user_programn;
      if (k == 300) pn300 = user_programn;
    end
    check("progn_128", 32'(pn128), 32'd1);
`ifdef ESP32_PROG_MULTIBOOT_EN
    check("progn_129", 32'(pn129), 32'd0);
    check("progn_300", 32'(pn300), 32'd0);
`else
    check("progn_129", 32'(pn129), 32'd1);
    check("progn_300", 32'(pn300), 32'd1);
`endif
    check("gpio0_btn0", 32'(wifi_gpio0), 32'd0);
    btn = 7'h7F;
    step(1);
    check("progn_release", 32'(user_programn), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
